// File: rtl/and_arb_pkg.sv
// Shared types and constants for the AND-gated capture register arbiter.
package and_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int CNT_W       = 8;
    localparam int NUM_REQ_DEF = 4;
    localparam int ID_W        = $clog2(NUM_REQ_DEF);

endpackage

// File: rtl/and_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               any,
    output logic [ID_W-1:0]    winner,
    output logic [NUM_REQ-1:0] onehot
);

    logic [NUM_REQ-1:0]   keep;
    logic [2*NUM_REQ-1:0] dbl;
    logic                 found;

    // Lower copy masked below ptr; the unmasked upper copy supplies the wrap-around.
    always_comb begin
        keep   = ~((NUM_REQ'(1) << ptr) - NUM_REQ'(1));
        dbl    = {req, req & keep};
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < 2 * NUM_REQ; i++) begin
            if (!found && dbl[i]) begin
                found  = 1'b1;
                winner = ID_W'(i % NUM_REQ);
            end
        end
        any    = |req;
        onehot = any ? (NUM_REQ'(1) << winner) : '0;
    end

endmodule

// File: rtl/and_reg_arbiter.sv
// Round-robin arbiter sharing one registered AND (q <= a & b) among NUM_REQ sources.
module and_reg_arbiter
    import and_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   a_in,
    input  logic [NUM_REQ*WIDTH-1:0]   b_in,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [WIDTH-1:0]           q,
    output logic                       q_valid,
    output logic [$clog2(NUM_REQ)-1:0] q_owner,
    output logic                       busy
);

    localparam int IDW = $clog2(NUM_REQ);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [IDW-1:0]   ptr;
    logic             any;
    logic [IDW-1:0]   winner;
    logic [NUM_REQ-1:0] onehot;
    logic             capture;

    rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(IDW)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .any    (any),
        .winner (winner),
        .onehot (onehot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: if (any) begin
                capture   = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: if (cnt == '0) begin
                if (any) capture   = 1'b1;
                else     state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Flush wins over a capture on the same edge.
        if (flush) begin
            capture   = 1'b0;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt     <= '0;
            q       <= '0;
            q_valid <= 1'b0;
            q_owner <= '0;
            cnt     <= '0;
            ptr     <= '0;
        end else begin
            gnt <= '0;
            if (flush) begin
                q_valid <= 1'b0;
                cnt     <= '0;
            end else if (capture) begin
                q       <= a_in[winner*WIDTH +: WIDTH] & b_in[winner*WIDTH +: WIDTH];
                q_owner <= winner;
                gnt     <= onehot;
                q_valid <= 1'b1;
                cnt     <= CNT_W'(HOLD_CYCLES - 1);
                ptr     <= (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + IDW'(1);
            end else if (state == HOLD) begin
                if (cnt != '0) cnt     <= cnt - CNT_W'(1);
                else           q_valid <= 1'b0;
            end
        end
    end

    assign busy = (state == HOLD);

endmodule

// File: doc/and_reg_arbiter.md
Name: and_reg_arbiter

Overview:
- Shares one AND-gated capture register (D <= A & B) between NUM_REQ requesters.
- A round-robin arbiter picks one pending requester and registers the bitwise AND of its two operands. It then holds the register occupied for HOLD_CYCLES cycles and reports the owner ID.
- Sits between multiple operand sources and a single downstream consumer of the gated register.

Parameters:
- NUM_REQ, 4, number of requesters; valid range 2..16.
- WIDTH, 8, operand and register width in bits.
- HOLD_CYCLES, 2, cycles q_valid stays high per grant; valid range 1..255.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort of the current hold.
- req  in  NUM_REQ  request bit per requester; held high until its gnt bit is seen.
- a_in  in  NUM_REQ*WIDTH  operand A per requester, packed; requester i in bits [i*WIDTH +: WIDTH].
- b_in  in  NUM_REQ*WIDTH  operand B per requester, same packing as a_in.
- gnt  out  NUM_REQ  registered one-hot grant pulse, exactly 1 cycle per grant.
- q  out  WIDTH  captured a_in[w] & b_in[w].
- q_valid  out  1  high while the register is held for the current owner.
- q_owner  out  $clog2(NUM_REQ)  index of the requester that owns q.
- busy  out  1  high in HOLD state.

Behaviour:
- Reset (async, rst=1): state=IDLE; gnt=0, q=0, q_valid=0, q_owner=0, busy=0, hold counter=0, priority pointer=0.
- FSM states: IDLE and HOLD.
- Winner w: the first set req bit scanning from the pointer upward, wrapping from NUM_REQ-1 to 0.
- Capture edge (taken from IDLE with |req, or from HOLD with cnt==0 and |req):
  - q <= a_in[w] & b_in[w]; q_owner <= w; gnt <= onehot(w).
  - q_valid <= 1; cnt <= HOLD_CYCLES-1; pointer <= (w+1) mod NUM_REQ; state <= HOLD.
- Latency: gnt, q and q_valid all appear on the cycle after the edge that samples req. That is 1 cycle from req to grant when idle.
- HOLD with cnt!=0: cnt <= cnt-1; gnt <= 0; req is ignored.
- HOLD with cnt==0 and no req: state <= IDLE; q_valid <= 0; busy <= 0; gnt <= 0.
- q and q_owner retain their last values after q_valid falls.
- Back-to-back: with continuous requests, q_valid stays high and each grant owns exactly HOLD_CYCLES cycles, with no idle gap.
- HOLD_CYCLES=1: a capture is possible on every cycle; cnt is always 0.
- flush=1 (synchronous, overrides capture): state <= IDLE; q_valid <= 0; gnt <= 0; cnt <= 0.
  - q, q_owner and pointer are unchanged.
  - req seen on the flush cycle is not granted.
- A req dropped before its grant is forgotten; no request is queued.
- A req kept high after its grant is a new request and competes normally under round-robin.
- Operands are sampled only on the capture edge; later changes to a_in/b_in do not affect q.
- Fairness: with all req high, the grant order is 0,1,2,…,NUM_REQ-1,0,…
- rst asserted mid-hold: all outputs clear immediately, without waiting for clk.

Decomposition:
- Package and_arb_pkg:
  - State enum: IDLE=1'b0, HOLD=1'b1.
  - localparam ID_W=$clog2(NUM_REQ).
  - localparam CNT_W=8.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req, pointer.
  - Outputs: any, winner index, one-hot.
  - Implemented as a double-width masked priority encoder.
- Top level holds the FSM, counter, operand mux, AND and output registers.

Test Plan:
- Reset: assert rst mid-simulation with q_valid=1 → q=0, q_valid=0, gnt=0, busy=0 immediately, before any clk edge.
- Single requester: req=4'b0100, a_in[2]=8'hF0, b_in[2]=8'h3C → next cycle gnt=4'b0100, q=8'h30, q_owner=2, q_valid=1 for 2 cycles, then 0.
- Round-robin: req=4'b1111 held, HOLD_CYCLES=2 → gnt pulses 0001,0010,0100,1000,0001 every 2 cycles; q_valid stays continuously high.
- Request during hold: req[1] pulsed high for 1 cycle while busy with cnt!=0 → no gnt[1]; q and q_owner unchanged.
- Flush: flush=1 on the first hold cycle → next cycle q_valid=0, busy=0; q retains its captured value; the pending req is granted on the following edge.
- Operand stability: change a_in[0] from 8'hFF to 8'h00 after gnt[0] → q stays 8'hFF & b_in[0] for the whole hold.
